serial_imm_ext: RTL and testbench

// - Bit-serial immediate assembler feeding the extender datapath: collects an IN_W-bit immediate LSB-first,

---
 rtl/serial_imm_ext.sv | 130 +++++++++++++
 tb/tb_serial_imm_ext.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_imm_ext.sv
// Bit-serial immediate assembler: collects IN_W bits LSB-first, then zero-, sign- or high-extends to OUT_W.
// Latency: out_valid rises 1 cycle after the last bit is accepted; bit_ready returns 1 cycle after the output handshake.
// Backpressure: while a result waits for out_ready, bit_ready is low and no bits are consumed.
module serial_imm_ext #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic [1:0]       ext_op,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int PAD   = OUT_W - IN_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IN_W-1:0]   sr, sr_nxt;
    logic [1:0]        op_q, op_nxt;
    logic [OUT_W-1:0]  data_nxt;
    logic              vld_nxt;

    logic                    accept;
    logic [IN_W-1:0]         imm_asm;
    logic signed [IN_W-1:0]  imm_sgn;
    logic [OUT_W-1:0]        ext_zero;
    logic [OUT_W-1:0]        ext_sign;
    logic [OUT_W-1:0]        ext_high;
    logic [OUT_W-1:0]        ext_res;

    assign bit_ready = (state != S_HOLD);
    assign busy      = (state != S_IDLE);
    assign accept    = bit_valid & bit_ready;

    // The word as it will look once the current bit is shifted in; on the
    // last bit this is the complete immediate, so the result is registered
    // straight from it without waiting a cycle for the shift register.
    assign imm_asm  = {bit_in, sr[IN_W-1:1]};
    assign imm_sgn  = imm_asm;
    assign ext_zero = OUT_W'(imm_asm);
    assign ext_sign = OUT_W'(imm_sgn);
    assign ext_high = ext_zero << PAD;

    // Extension select from the op latched with the first bit; 11 behaves as zero-extend.
    always_comb begin
        ext_res = ext_zero;
        case (op_q)
            2'b01:   ext_res = ext_sign;
            2'b10:   ext_res = ext_high;
            default: ext_res = ext_zero;
        endcase
    end

    // Next-state and datapath update: collect bits, finish the word, wait for the consumer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        op_nxt    = op_q;
        data_nxt  = out_data;
        vld_nxt   = out_valid;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_nxt    = ext_op;
                    sr_nxt    = imm_asm;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    sr_nxt = imm_asm;
                    if (cnt == CNT_W'(IN_W - 1)) begin
                        data_nxt  = ext_res;
                        vld_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_HOLD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    vld_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // State register; reset discards any partial word and drops a pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sr        <= '0;
            op_q      <= 2'b00;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sr        <= sr_nxt;
            op_q      <= op_nxt;
            out_data  <= data_nxt;
            out_valid <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_serial_imm_ext.sv
// Directed bench for serial_imm_ext with hand-computed expected results.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// The output consumer is driven by the bench to exercise hold/backpressure.
module tb_serial_imm_ext;

    logic        clk;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [1:0]  ext_op;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int errors;
    int checks;
    int accepted;

    serial_imm_ext #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .ext_op    (ext_op),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift one word LSB-first; ext_op is op on bit 0 and op_after afterwards.
    task automatic send_word(input logic [15:0] w, input logic [1:0] op,
                             input logic [1:0] op_after, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'b1;
                    step();
                end
            end
            bit_valid = 1'b1;
            bit_in    = w[i];
            ext_op    = (i == 0) ? op : op_after;
            if (bit_ready) accepted++;
            if (i == 15) chk("valid_before_last", {31'd0, out_valid}, 32'd0);
            step();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Check a presented result, then take it and confirm the return to IDLE.
    task automatic expect_result(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_rdy_low"}, {31'd0, bit_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk({tag, "_valid_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, bit_ready}, 32'd1);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        accepted  = 0;
        reset     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        ext_op    = 2'b00;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ready", {31'd0, bit_ready}, 32'd1);

        // T1 sign extend, consumer ready throughout
        out_ready = 1'b1;
        send_word(16'h8001, 2'b01, 2'b01, 1'b0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        expect_result("t1", 32'hFFFF8001);

        // T2 zero extend and op 11
        send_word(16'h8001, 2'b00, 2'b00, 1'b0);
        expect_result("t2a", 32'h00008001);
        send_word(16'hF00F, 2'b11, 2'b11, 1'b0);
        expect_result("t2b", 32'h0000F00F);

        // T3 high extend, then ext_op change after bit 1 must not matter
        send_word(16'h1234, 2'b10, 2'b10, 1'b0);
        expect_result("t3a", 32'h12340000);
        send_word(16'h1234, 2'b10, 2'b01, 1'b0);
        expect_result("t3b", 32'h12340000);
        send_word(16'h8001, 2'b00, 2'b01, 1'b0);
        expect_result("t3c", 32'h00008001);

        // T4 gaps and output backpressure
        out_ready = 1'b0;
        send_word(16'h7FFF, 2'b01, 2'b01, 1'b1);
        for (int c = 0; c < 5; c++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            ext_op    = 2'b10;
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_data", out_data, 32'h00007FFF);
            chk("t4_hold_rdy", {31'd0, bit_ready}, 32'd0);
            step();
        end
        bit_valid = 1'b0;
        expect_result("t4", 32'h00007FFF);

        // T5 reset after 7 bits discards the partial word
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            ext_op    = 2'b10;
            step();
        end
        bit_valid = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        send_word(16'hFFFF, 2'b01, 2'b01, 1'b0);
        expect_result("t5", 32'hFFFFFFFF);
        send_word(16'h0001, 2'b00, 2'b00, 1'b0);
        expect_result("t5b", 32'h00000001);

        // T5b reset while a result is held drops it without a handshake
        out_ready = 1'b0;
        send_word(16'h00FF, 2'b01, 2'b01, 1'b0);
        chk("t5c_held", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        chk("t5c_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("t5c_drop_busy", {31'd0, busy}, 32'd0);

        // T6 back-to-back words; a bit offered during the handshake cycle is not taken
        accepted  = 0;
        out_ready = 1'b1;
        send_word(16'hA5A5, 2'b00, 2'b00, 1'b0);
        chk("t6a_valid", {31'd0, out_valid}, 32'd1);
        chk("t6a_data", out_data, 32'h0000A5A5);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        ext_op    = 2'b01;
        chk("t6_nobypass", {31'd0, bit_ready}, 32'd0);
        if (bit_ready) accepted++;
        step();
        bit_valid = 1'b0;
        chk("t6_rdy_next", {31'd0, bit_ready}, 32'd1);
        chk("t6_valid_clr", {31'd0, out_valid}, 32'd0);
        send_word(16'h0001, 2'b10, 2'b10, 1'b0);
        expect_result("t6b", 32'h00010000);
        chk("t6_bits", accepted, 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
